// File: rtl/uart_rx_frame_if.sv
// Serial line plus received byte/strobe bundle between the UART receiver and the echo control stage.
// master: the receiver side. slave: the line driver and byte consumer.
interface uart_rx_frame_if;
    logic       UART_RX;
    logic [7:0] RX_DATA;
    logic       RX_STATUS;
    logic       RX_FRAME_ERR;

    modport master (
        input  UART_RX,
        output RX_DATA,
        output RX_STATUS,
        output RX_FRAME_ERR
    );

    modport slave (
        output UART_RX,
        input  RX_DATA,
        input  RX_STATUS,
        input  RX_FRAME_ERR
    );
endinterface

// File: rtl/uart_rx_frame.sv
// UART receive front end: 8N1 deserialiser with 3-sample majority voting per bit.
// Define UART_RX_PARITY_EN to receive 8E1 frames and reject frames that fail the even-parity check.
module uart_rx_frame #(
    parameter int unsigned CLKS_PER_BIT = 5208
) (
    input logic             clk,
    input logic             rst,
    uart_rx_frame_if.master bus
);

    localparam int unsigned Mid     = CLKS_PER_BIT / 2;
    localparam logic [15:0] CntLast = 16'(CLKS_PER_BIT - 1);
    localparam logic [15:0] SmpA    = 16'(Mid - 1);
    localparam logic [15:0] SmpB    = 16'(Mid);
    localparam logic [15:0] SmpC    = 16'(Mid + 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StBreak} state_e;
`else
    typedef enum logic [2:0] {StIdle, StStart, StData, StStop, StBreak} state_e;
`endif

    state_e      state_q, state_d;
    logic        sync1_q, rx_s_q;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [1:0]  smp_q, smp_d;
    logic [7:0]  data_q, data_d;
    logic        status_q, status_d;
    logic        ferr_q, ferr_d;

    logic wrap;
    logic decide;
    logic maj;
    logic parity_good;

    assign wrap   = (cnt_q == CntLast);
    assign decide = (cnt_q == SmpC);
    // Third vote is the live sample taken on the decision cycle.
    assign maj    = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s_q) | (smp_q[1] & rx_s_q);

`ifdef UART_RX_PARITY_EN
    logic parity_ok_q, parity_ok_d;
    assign parity_good = parity_ok_q;
`else
    assign parity_good = 1'b1;
`endif

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= StIdle;
            cnt_q       <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            smp_q       <= '0;
            data_q      <= '0;
            status_q    <= 1'b0;
            ferr_q      <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_ok_q <= 1'b0;
`endif
        end else begin
            sync1_q     <= bus.UART_RX;
            rx_s_q      <= sync1_q;
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            smp_q       <= smp_d;
            data_q      <= data_d;
            status_q    <= status_d;
            ferr_q      <= ferr_d;
`ifdef UART_RX_PARITY_EN
            parity_ok_q <= parity_ok_d;
`endif
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (!rx_s_q) state_d = StStart;
            end
            StStart: begin
                if (decide && maj) state_d = StIdle;
                else if (wrap)     state_d = StData;
            end
            StData: begin
                if (wrap && (idx_q == 3'd7)) begin
`ifdef UART_RX_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StStop;
`endif
                end
            end
`ifdef UART_RX_PARITY_EN
            StParity: begin
                if (wrap) state_d = StStop;
            end
`endif
            StStop: begin
                // A good stop returns early so a back-to-back start bit is not missed.
                if (decide) state_d = (maj && parity_good) ? StIdle : StBreak;
            end
            StBreak: begin
                if (rx_s_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Datapath and registered-output next values.
    always_comb begin
        cnt_d    = cnt_q + 16'd1;
        idx_d    = idx_q;
        shift_d  = shift_q;
        smp_d    = smp_q;
        data_d   = data_q;
        status_d = 1'b0;
        ferr_d   = 1'b0;

        if (state_q == StIdle || state_q == StBreak || state_d == StIdle || wrap) begin
            cnt_d = '0;
        end

        if (cnt_q == SmpA) smp_d[0] = rx_s_q;
        if (cnt_q == SmpB) smp_d[1] = rx_s_q;

        if (state_q == StData) begin
            if (decide) shift_d[idx_q] = maj;
            if (wrap)   idx_d = idx_q + 3'd1;
        end else begin
            idx_d = '0;
        end

        if (state_q == StStop && decide) begin
            if (maj && parity_good) begin
                data_d   = shift_q;
                status_d = 1'b1;
            end else begin
                ferr_d   = 1'b1;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    // Even parity: the parity bit must equal the XOR of the data bits.
    always_comb begin
        parity_ok_d = parity_ok_q;
        if (state_q == StParity && decide) parity_ok_d = (maj == ^shift_q);
    end
`endif

    assign bus.RX_DATA      = data_q;
    assign bus.RX_STATUS    = status_q;
    assign bus.RX_FRAME_ERR = ferr_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Self-checking bench for uart_rx_frame: directed scenarios plus randomized frames against a
// frame-level reference model (valid frame => byte delivered, otherwise one error pulse).
module tb_uart_rx_frame;

    localparam int Cpb = 16;
    localparam int Mid = Cpb / 2;
    localparam int ExpLatency = 2 + 9 * Cpb + Mid + 2;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_frame_if bus ();

    uart_rx_frame #(.CLKS_PER_BIT(Cpb)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: observes pulses away from the active edge.
    int          status_cnt  = 0;
    int          ferr_cnt    = 0;
    int          overlap_cnt = 0;
    int          wide_cnt    = 0;
    logic        prev_status = 1'b0;
    logic        prev_ferr   = 1'b0;
    logic [7:0]  rx_q[$];
    int unsigned last_status_cyc = 0;

    always @(negedge clk) begin
        if (bus.RX_STATUS) begin
            status_cnt++;
            rx_q.push_back(bus.RX_DATA);
            last_status_cyc = cyc;
        end
        if (bus.RX_FRAME_ERR) ferr_cnt++;
        if (bus.RX_STATUS && bus.RX_FRAME_ERR) overlap_cnt++;
        if ((bus.RX_STATUS && prev_status) || (bus.RX_FRAME_ERR && prev_ferr)) wide_cnt++;
        prev_status = bus.RX_STATUS;
        prev_ferr   = bus.RX_FRAME_ERR;
    end

    // Reference model state.
    logic [7:0]  model_data = 8'h00;
    logic [7:0]  exp_q[$];
    int          model_ferr = 0;
    int unsigned start_cyc  = 0;

    task automatic drive_bit(input logic v, input int n);
        bus.UART_RX = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        drive_bit(1'b1, n);
    endtask

    // Sends one frame; stop_len counts bit times the stop level is held.
    task automatic send_frame(input logic [7:0] data, input logic stop_val, input int stop_len,
                              input logic par_bad);
        start_cyc = cyc;
        drive_bit(1'b0, Cpb);
        for (int i = 0; i < 8; i++) drive_bit(data[i], Cpb);
`ifdef UART_RX_PARITY_EN
        drive_bit((^data) ^ par_bad, Cpb);
        if (stop_val && !par_bad) begin
`else
        if (stop_val) begin
`endif
            exp_q.push_back(data);
            model_data = data;
        end else begin
            model_ferr++;
        end
        drive_bit(stop_val, Cpb * stop_len);
        bus.UART_RX = 1'b1;
    endtask

    task automatic test_reset;
        int s0;
        int f0;
        rst = 1'b1;
        bus.UART_RX = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        compared++;
        if (bus.RX_DATA !== 8'h00 || bus.RX_STATUS !== 1'b0 || bus.RX_FRAME_ERR !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_outputs: got data=%h st=%b err=%b, want 00/0/0",
                     bus.RX_DATA, bus.RX_STATUS, bus.RX_FRAME_ERR);
        end
        rst = 1'b0;
        s0 = status_cnt;
        f0 = ferr_cnt;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            compared++;
            if (bus.RX_DATA !== 8'h00 || bus.RX_STATUS !== 1'b0 || bus.RX_FRAME_ERR !== 1'b0) begin
                mismatched++;
                $display("FAIL idle_outputs cycle %0d: got data=%h st=%b err=%b, want 00/0/0",
                         i, bus.RX_DATA, bus.RX_STATUS, bus.RX_FRAME_ERR);
            end
        end
        compared++;
        if (status_cnt - s0 != 0 || ferr_cnt - f0 != 0) begin
            mismatched++;
            $display("FAIL idle_pulses: got st=%0d err=%0d, want 0/0",
                     status_cnt - s0, ferr_cnt - f0);
        end
    endtask

    task automatic test_valid_frame;
        int s0;
        int f0;
        int lat;
        logic [7:0] got;
        s0 = status_cnt;
        f0 = ferr_cnt;
        send_frame(8'hA5, 1'b1, 1, 1'b0);
        idle(Cpb);
        compared++;
        if (status_cnt - s0 != 1) begin
            mismatched++;
            $display("FAIL valid_status_count: got %0d, want 1", status_cnt - s0);
        end
        compared++;
        if (ferr_cnt - f0 != 0) begin
            mismatched++;
            $display("FAIL valid_no_err: got %0d err pulses, want 0", ferr_cnt - f0);
        end
        lat = int'(last_status_cyc - start_cyc);
        compared++;
        if (lat < ExpLatency - 1 || lat > ExpLatency + 1) begin
            mismatched++;
            $display("FAIL valid_latency: got %0d cycles, want %0d +-1", lat, ExpLatency);
        end
        compared++;
        if (bus.RX_DATA !== 8'hA5) begin
            mismatched++;
            $display("FAIL valid_data: got %h, want a5", bus.RX_DATA);
        end
        while (exp_q.size() > 0) begin
            compared++;
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            if (got !== exp_q[0]) begin
                mismatched++;
                $display("FAIL valid_stream: got %h, want %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

    task automatic test_back_to_back;
        int s0;
        int f0;
        logic [7:0] got;
        s0 = status_cnt;
        send_frame(8'h00, 1'b1, 1, 1'b0);
        send_frame(8'hFF, 1'b1, 1, 1'b0);
        idle(2 * Cpb);
        compared++;
        if (status_cnt - s0 != 2) begin
            mismatched++;
            $display("FAIL b2b_status_count: got %0d, want 2", status_cnt - s0);
        end
        while (exp_q.size() > 0) begin
            compared++;
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            if (got !== exp_q[0]) begin
                mismatched++;
                $display("FAIL b2b_stream: got %h, want %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        s0 = status_cnt;
        f0 = ferr_cnt;
        drive_bit(1'b0, 4);
        idle(3 * Cpb);
        compared++;
        if (status_cnt - s0 != 0 || ferr_cnt - f0 != 0) begin
            mismatched++;
            $display("FAIL glitch_pulses: got st=%0d err=%0d, want 0/0",
                     status_cnt - s0, ferr_cnt - f0);
        end
        compared++;
        if (bus.RX_DATA !== 8'hFF) begin
            mismatched++;
            $display("FAIL glitch_data: got %h, want ff", bus.RX_DATA);
        end
    endtask

    task automatic test_framing_error;
        int s0;
        int f0;
        logic [7:0] prev;
        logic [7:0] got;
        prev = model_data;
        s0 = status_cnt;
        f0 = ferr_cnt;
        send_frame(8'h3C, 1'b0, 3, 1'b0);
        idle(2 * Cpb);
        compared++;
        if (ferr_cnt - f0 != 1 || status_cnt - s0 != 0) begin
            mismatched++;
            $display("FAIL ferr_pulses: got err=%0d st=%0d, want 1/0",
                     ferr_cnt - f0, status_cnt - s0);
        end
        compared++;
        if (bus.RX_DATA !== prev) begin
            mismatched++;
            $display("FAIL ferr_data_held: got %h, want %h", bus.RX_DATA, prev);
        end
        s0 = status_cnt;
        send_frame(8'h81, 1'b1, 1, 1'b0);
        idle(Cpb);
        compared++;
        if (status_cnt - s0 != 1 || bus.RX_DATA !== 8'h81) begin
            mismatched++;
            $display("FAIL ferr_recover: got st=%0d data=%h, want 1/81",
                     status_cnt - s0, bus.RX_DATA);
        end
        while (exp_q.size() > 0) begin
            compared++;
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            if (got !== exp_q[0]) begin
                mismatched++;
                $display("FAIL ferr_stream: got %h, want %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
    endtask

`ifdef UART_RX_PARITY_EN
    task automatic test_parity;
        int s0;
        int f0;
        s0 = status_cnt;
        f0 = ferr_cnt;
        send_frame(8'h07, 1'b1, 1, 1'b0);
        idle(Cpb);
        compared++;
        if (status_cnt - s0 != 1 || ferr_cnt - f0 != 0 || bus.RX_DATA !== 8'h07) begin
            mismatched++;
            $display("FAIL parity_good: got st=%0d err=%0d data=%h, want 1/0/07",
                     status_cnt - s0, ferr_cnt - f0, bus.RX_DATA);
        end
        s0 = status_cnt;
        f0 = ferr_cnt;
        send_frame(8'h07, 1'b1, 1, 1'b1);
        idle(2 * Cpb);
        compared++;
        if (status_cnt - s0 != 0 || ferr_cnt - f0 != 1) begin
            mismatched++;
            $display("FAIL parity_bad: got st=%0d err=%0d, want 0/1",
                     status_cnt - s0, ferr_cnt - f0);
        end
        rx_q.delete();
        exp_q.delete();
    endtask
`endif

    task automatic test_reset_mid_frame;
        int s0;
        int f0;
        logic [7:0] d;
        d = 8'h5A;
        s0 = status_cnt;
        f0 = ferr_cnt;
        drive_bit(1'b0, Cpb);
        for (int i = 0; i < 4; i++) drive_bit(d[i], Cpb);
        drive_bit(d[4], Cpb / 2);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        model_data = 8'h00;
        idle(3 * Cpb);
        compared++;
        if (status_cnt - s0 != 0 || ferr_cnt - f0 != 0) begin
            mismatched++;
            $display("FAIL abort_pulses: got st=%0d err=%0d, want 0/0",
                     status_cnt - s0, ferr_cnt - f0);
        end
        compared++;
        if (bus.RX_DATA !== 8'h00) begin
            mismatched++;
            $display("FAIL abort_data: got %h, want 00", bus.RX_DATA);
        end
        s0 = status_cnt;
        send_frame(8'hC3, 1'b1, 1, 1'b0);
        idle(Cpb);
        compared++;
        if (status_cnt - s0 != 1 || bus.RX_DATA !== 8'hC3) begin
            mismatched++;
            $display("FAIL abort_recover: got st=%0d data=%h, want 1/c3",
                     status_cnt - s0, bus.RX_DATA);
        end
        rx_q.delete();
        exp_q.delete();
    endtask

    task automatic test_random;
        int s0;
        int f0;
        int m0;
        int n_exp;
        logic [7:0] d;
        logic stop_val;
        logic par_bad;
        logic [7:0] got;
        s0 = status_cnt;
        f0 = ferr_cnt;
        m0 = model_ferr;
        for (int k = 0; k < 24; k++) begin
            d        = 8'($urandom);
            stop_val = ($urandom_range(3) != 0);
            par_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad  = ($urandom_range(4) == 0);
`endif
            send_frame(d, stop_val, 1, par_bad);
            if (!stop_val || par_bad) idle(2 * Cpb + $urandom_range(Cpb));
            else if ($urandom_range(1) == 1) idle($urandom_range(Cpb));
        end
        idle(2 * Cpb);
        n_exp = exp_q.size();
        compared++;
        if (status_cnt - s0 != n_exp) begin
            mismatched++;
            $display("FAIL rand_status_count: got %0d, want %0d", status_cnt - s0, n_exp);
        end
        compared++;
        if (ferr_cnt - f0 != model_ferr - m0) begin
            mismatched++;
            $display("FAIL rand_err_count: got %0d, want %0d", ferr_cnt - f0, model_ferr - m0);
        end
        while (exp_q.size() > 0) begin
            compared++;
            got = (rx_q.size() > 0) ? rx_q.pop_front() : 8'hxx;
            if (got !== exp_q[0]) begin
                mismatched++;
                $display("FAIL rand_stream: got %h, want %h", got, exp_q[0]);
            end
            void'(exp_q.pop_front());
        end
        compared++;
        if (bus.RX_DATA !== model_data) begin
            mismatched++;
            $display("FAIL rand_last_data: got %h, want %h", bus.RX_DATA, model_data);
        end
    endtask

    task automatic test_pulse_shape;
        compared++;
        if (overlap_cnt != 0) begin
            mismatched++;
            $display("FAIL pulse_overlap: got %0d overlapping cycles, want 0", overlap_cnt);
        end
        compared++;
        if (wide_cnt != 0) begin
            mismatched++;
            $display("FAIL pulse_width: got %0d multi-cycle pulses, want 0", wide_cnt);
        end
    endtask

    initial begin
        bus.UART_RX = 1'b1;
        test_reset();
        test_valid_frame();
        test_back_to_back();
        test_framing_error();
`ifdef UART_RX_PARITY_EN
        test_parity();
`endif
        test_reset_mid_frame();
        test_random();
        test_pulse_shape();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

UART receive front end that deserialises 8N1 frames from the external RX pin into the byte/strobe pair consumed by the echo control stage. Delivers a byte on `RX_DATA` with a one-cycle `RX_STATUS` strobe per valid frame, and flags framing errors separately. It sits directly upstream of the control stage. Its outputs feed that stage's `RX_DATA`/`RX_STATUS` inputs without glue.

## Interface
- `CLKS_PER_BIT`, default 5208: `clk` cycles per UART bit (50 MHz / 9600 baud); legal range 8..65535.
- `clk`  input  1  system clock; all logic on rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `UART_RX`  input  1  serial line, idle high, asynchronous to `clk`.
- `RX_DATA`  output  8  last correctly received byte; holds until next valid frame.
- `RX_STATUS`  output  1  one-cycle pulse: `RX_DATA` just updated.
- `RX_FRAME_ERR`  output  1  one-cycle pulse: frame rejected (bad stop bit or parity).

## Operation
- Input path: 2-flop synchroniser on `UART_RX`. Both flops reset to 1. All decisions use the second flop (`rx_s`).
- Bit counter: 16-bit clock counter `cnt`, 3-bit data index `idx`, 8-bit LSB-first shift register.
- Sampling: let `MID = CLKS_PER_BIT/2` (integer divide).
  - Each bit is sampled at `cnt = MID-1`, `MID` and `MID+1`.
  - The bit value is the 2-of-3 majority. The decision is taken at `cnt = MID+1`.
  - `cnt` wraps to 0 at `CLKS_PER_BIT-1`.
- States:
  - IDLE: `cnt=0`. On `rx_s==0`, go to START with `cnt=0`.
  - START: on decision, majority 1 is a glitch; return to IDLE with no output. Majority 0 stays in START until `cnt` wraps, then goes to DATA with `idx=0`.
  - DATA: on decision, shift the majority into bit `idx`. At wrap, if `idx==7` go to PARITY (when enabled) or STOP; otherwise increment `idx`.
  - PARITY: sample the parity bit, latch a parity-ok flag, go to STOP at wrap.
  - STOP, decision with majority 1 and parity ok:
    - load `RX_DATA` from the shift register;
    - pulse `RX_STATUS`;
    - go to IDLE at once, without waiting for wrap, so a back-to-back start bit is caught.
  - STOP, decision with majority 0 or parity bad:
    - pulse `RX_FRAME_ERR`; `RX_DATA` unchanged;
    - go to BREAK.
  - BREAK: wait for `rx_s==1`, then go to IDLE. This absorbs line breaks with no further pulses.
- `RX_STATUS` and `RX_FRAME_ERR` are never high in the same cycle. Each is high for exactly one cycle per frame.

## Timing
- Reset values: `RX_DATA=8'h00`, `RX_STATUS=0`, `RX_FRAME_ERR=0`, state IDLE, counters 0, synchroniser flops 1.
- Reset mid-frame aborts the frame immediately with no output pulse. The block resumes in IDLE.
- Pin-to-detect latency: 2 cycles from a `UART_RX` falling edge to `rx_s==0`.
- `RX_STATUS` timing: high on the cycle after the STOP decision edge, i.e. the registered output of that edge. Measured from the start-bit falling edge on the pin, this is about `2 + 9*CLKS_PER_BIT + MID + 2` cycles (8N1).
- `RX_DATA` changes in the same cycle `RX_STATUS` rises. It is stable for at least one full frame afterwards.
- No backpressure. The downstream stage must accept the strobe; a missed strobe loses the byte.
- Glitches: low pulses shorter than `MID-1` cycles are rejected in START.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - frame is 8E1: an even-parity bit follows the data;
  - the PARITY state exists;
  - a parity mismatch gives `RX_FRAME_ERR` and no `RX_STATUS`.
- Not defined:
  - 8N1; the PARITY state and its flag are not synthesised;
  - STOP follows DATA directly.

## Test plan
- Reset and idle:
  - Stimulus: `CLKS_PER_BIT=16`, assert `rst` for 3 cycles, line idle high for 200 cycles.
  - Required: all outputs 0 throughout and no pulses.
- Valid frame:
  - Stimulus: send `8'hA5` in 8N1 at 16 clk/bit.
  - Required: `RX_DATA=8'hA5` with exactly one `RX_STATUS` pulse, 2+9*16+8+2=156 ±1 cycles after the start edge, and `RX_FRAME_ERR` stays 0.
- Back-to-back and glitch rejection:
  - Stimulus: send `8'h00` then `8'hFF` with no idle gap between frames. Then drive a 4-cycle low glitch.
  - Required: two `RX_STATUS` pulses with `RX_DATA` = 00 then FF, and no response to the glitch.
- Framing error:
  - Stimulus: send `8'h3C` with the stop bit held 0 for 3 bit times.
  - Required: one `RX_FRAME_ERR` pulse, `RX_DATA` keeps its previous value, no `RX_STATUS`, and the next valid frame `8'h81` is received correctly.
- Parity (`UART_RX_PARITY_EN`):
  - Stimulus: send `8'h07` with parity bit 1, then with parity bit 0.
  - Required: the first gives `RX_STATUS` with `RX_DATA=8'h07`; the second gives `RX_FRAME_ERR` only.
- Reset mid-frame:
  - Stimulus: assert `rst` during data bit 4 of `8'h5A`, then send `8'hC3`.
  - Required: no pulse for the aborted frame, then `RX_DATA=8'hC3` with `RX_STATUS`.
